plan_act_sched: RTL and testbench

- Round-robin scheduler that shares one PLAN activation datapath (coefficient lookup plus FP multiply-add, fixed latency LAT) among NREQ requesters.
- Accepts at most one IEEE-754 single operand per cycle, drives it into the datapath with a tag, tracks in-flight tags, and routes each returned result to its originating requester.
- Supports a hold/drain handshake so the datapath can be quiesced, e.g. for coefficient reconfiguration.

---
 rtl/plan_act_sched_if.sv | 31 +++
 rtl/plan_act_sched.sv | 121 ++++++++++++
 tb/tb_plan_act_sched.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plan_act_sched_if.sv
// Bundle of requester, datapath and response signals shared by plan_act_sched and its environment.
// The slave modport is the scheduler's view; the master modport is the requesters plus the datapath.
interface plan_act_sched_if #(
    parameter int NREQ = 4,
    parameter int TW   = 3
);
    logic [NREQ-1:0]    req_vld;
    logic [32*NREQ-1:0] req_data;
    logic [NREQ-1:0]    req_rdy;
    logic               hold;
    logic               hold_ack;
    logic [31:0]        dp_num;
    logic               dp_vld;
    logic [TW-1:0]      dp_tag;
    logic [31:0]        dp_res;
    logic               dp_res_vld;
    logic [NREQ-1:0]    rsp_vld;
    logic [31:0]        rsp_data;
    logic               busy;
    logic               err;

    modport slave (
        input  req_vld, req_data, hold, dp_res, dp_res_vld,
        output req_rdy, hold_ack, dp_num, dp_vld, dp_tag, rsp_vld, rsp_data, busy, err
    );

    modport master (
        output req_vld, req_data, hold, dp_res, dp_res_vld,
        input  req_rdy, hold_ack, dp_num, dp_vld, dp_tag, rsp_vld, rsp_data, busy, err
    );
endinterface

// File: rtl/plan_act_sched.sv
// Round-robin sharing of one fixed-latency PLAN activation datapath among NREQ requesters,
// with tag tracking for result routing and a hold/drain handshake for quiescing the datapath.
module plan_act_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 3,
    parameter int TW   = 3
) (
    input  logic                clk,
    input  logic                res,
    plan_act_sched_if.slave     bus,
    output logic [1:0]          dbg_state
);
    // Handshake: requester i transfers on a posedge where req_vld[i] & req_rdy[i]; req_rdy is
    // one-hot, combinational from req_vld and state, and rsp_vld has no ready (never backpressured).
    typedef enum logic [1:0] {
        ISSUE  = 2'd0,
        DRAIN  = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [TW-1:0]       ptr;
    logic [NREQ-1:0]     gnt;
    logic [TW-1:0]       gnt_idx;
    logic                found;
    int                  cand;
    logic                accept;

    logic                dp_vld_q;
    logic [31:0]         dp_num_q;
    logic [TW-1:0]       dp_tag_q;
    logic [LAT-1:0]      pipe_vld;
    logic [TW-1:0]       pipe_tag [LAT];
    logic [NREQ-1:0]     rsp_vld_q;
    logic [31:0]         rsp_data_q;
    logic                err_q;
    logic                exp_vld;
    logic [TW-1:0]       exp_tag;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        cand    = 0;
        if (state == ISSUE && !bus.hold) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = int'(ptr) + k;
                if (cand >= NREQ) cand = cand - NREQ;
                if (!found && bus.req_vld[cand]) begin
                    found     = 1'b1;
                    gnt[cand] = 1'b1;
                    gnt_idx   = TW'(cand);
                end
            end
        end
    end

    assign accept  = found;
    assign exp_vld = pipe_vld[LAT-1];
    assign exp_tag = pipe_tag[LAT-1];

    always_comb begin
        state_nxt = state;
        case (state)
            ISSUE:   if (bus.hold) state_nxt = DRAIN;
            DRAIN:   if (!bus.hold) state_nxt = ISSUE;
                     else if (!bus.busy) state_nxt = PAUSED;
            PAUSED:  if (!bus.hold) state_nxt = ISSUE;
            default: state_nxt = ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state      <= ISSUE;
            ptr        <= '0;
            dp_vld_q   <= 1'b0;
            dp_num_q   <= '0;
            dp_tag_q   <= '0;
            pipe_vld   <= '0;
            for (int k = 0; k < LAT; k++) pipe_tag[k] <= '0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state    <= state_nxt;
            dp_vld_q <= accept;
            if (accept) begin
                dp_num_q <= bus.req_data[int'(gnt_idx)*32 +: 32];
                dp_tag_q <= gnt_idx;
                ptr      <= (gnt_idx == TW'(NREQ-1)) ? '0 : gnt_idx + TW'(1);
            end
            // Slot LAT-1 holds the issue whose result is due this cycle.
            pipe_vld[0] <= dp_vld_q;
            pipe_tag[0] <= dp_tag_q;
            for (int k = 1; k < LAT; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_tag[k] <= pipe_tag[k-1];
            end
            if (bus.dp_res_vld && exp_vld) begin
                rsp_vld_q  <= NREQ'(1) << exp_tag;
                rsp_data_q <= bus.dp_res;
            end else begin
                rsp_vld_q  <= '0;
            end
            if (bus.dp_res_vld != exp_vld) err_q <= 1'b1;
        end
    end

    assign bus.req_rdy  = gnt;
    assign bus.dp_vld   = dp_vld_q;
    assign bus.dp_num   = dp_num_q;
    assign bus.dp_tag   = dp_tag_q;
    assign bus.rsp_vld  = rsp_vld_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.err      = err_q;
    assign bus.busy     = (|pipe_vld) | dp_vld_q;
    assign bus.hold_ack = (state == PAUSED);
    assign dbg_state    = state;
endmodule

// File: tb/tb_plan_act_sched.sv
// Bench for plan_act_sched: cycle-level reference model plus end-to-end response scoreboard,
// a grant vector table, hand-written corner sequences and a randomized soak.
module tb_plan_act_sched;
    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int TW   = 3;
    localparam int SBW  = NREQ + 32;

    logic       clk;
    logic       res;
    logic [1:0] dbg_state;

    plan_act_sched_if #(.NREQ(NREQ), .TW(TW)) bus ();

    plan_act_sched #(.NREQ(NREQ), .LAT(LAT), .TW(TW)) dut (
        .clk       (clk),
        .res       (res),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model state ----------------
    typedef struct { int tag; int due; } fl_t;
    typedef struct { bit vld; logic [31:0] num; } dl_t;
    typedef struct { logic [NREQ-1:0] vld; logic [NREQ-1:0] rdy; } vec_t;

    fl_t              fl_q[$];
    dl_t              dl_q[$];
    logic [SBW-1:0]   exp_q[$];
    int               m_ptr, m_mode, cyc;
    bit               e_dp_vld, e_err;
    logic [31:0]      e_dp_num, e_rsp_data;
    int               e_dp_tag;
    logic [NREQ-1:0]  e_rsp_vld;

    int               n_checks, n_errors;
    int               n_rsp_total;
    int               n_rsp_req [NREQ];
    logic [NREQ-1:0]  last_rdy;
    bit               last_busy, last_hold_ack;

    function automatic logic [31:0] dp_fn(input logic [31:0] x);
        return {x[15:0], x[31:16]} ^ 32'h3c5a_a5c3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_mode = 0;
        e_dp_vld = 0; e_dp_num = '0; e_dp_tag = 0;
        e_rsp_vld = '0; e_rsp_data = '0; e_err = 0;
        fl_q.delete();
        exp_q.delete();
    endtask

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) bus.req_data[i*32 +: 32] = $urandom;
    endtask

    // ---------------- driver: one clock cycle with full checking ----------------
    task automatic step();
        bit              exp_v, busy_e;
        int              exp_t, gi;
        logic [NREQ-1:0] g;
        dl_t             d;
        logic [SBW-1:0]  item;
        #1;
        while (fl_q.size() > 0 && fl_q[0].due < cyc) void'(fl_q.pop_front());
        exp_v = 0; exp_t = 0;
        if (fl_q.size() > 0 && fl_q[0].due == cyc) begin
            exp_v = 1; exp_t = fl_q[0].tag;
        end
        busy_e = e_dp_vld || (fl_q.size() > 0);
        g = '0; gi = 0;
        if (m_mode == 0 && !bus.hold) begin
            for (int k = 0; k < NREQ; k++) begin
                int c = (m_ptr + k) % NREQ;
                if (g == '0 && bus.req_vld[c]) begin g[c] = 1'b1; gi = c; end
            end
        end
        last_rdy = bus.req_rdy; last_busy = bus.busy; last_hold_ack = bus.hold_ack;
        chk("req_rdy", 64'(bus.req_rdy), 64'(g));
        chk("busy", 64'(bus.busy), 64'(busy_e));
        chk("hold_ack", 64'(bus.hold_ack), 64'(m_mode == 2));

        if (!res) begin
            model_reset();
        end else begin
            if (e_dp_vld) fl_q.push_back('{e_dp_tag, cyc + LAT});
            if (bus.dp_res_vld && exp_v) begin
                e_rsp_vld = NREQ'(1) << exp_t; e_rsp_data = bus.dp_res;
            end else begin
                e_rsp_vld = '0;
            end
            if (bus.dp_res_vld != exp_v) e_err = 1;
            if (g != '0) begin
                e_dp_vld = 1; e_dp_num = bus.req_data[gi*32 +: 32]; e_dp_tag = gi;
                m_ptr = (gi + 1) % NREQ;
                exp_q.push_back({g, dp_fn(e_dp_num)});
            end else begin
                e_dp_vld = 0;
            end
            case (m_mode)
                0: if (bus.hold) m_mode = 1;
                1: if (!bus.hold) m_mode = 0; else if (!busy_e) m_mode = 2;
                default: if (!bus.hold) m_mode = 0;
            endcase
        end

        @(posedge clk);
        #1;
        cyc++;
        chk("dp_vld", 64'(bus.dp_vld), 64'(e_dp_vld));
        chk("dp_num", 64'(bus.dp_num), 64'(e_dp_num));
        chk("dp_tag", 64'(bus.dp_tag), 64'(e_dp_tag));
        chk("rsp_vld", 64'(bus.rsp_vld), 64'(e_rsp_vld));
        chk("rsp_data", 64'(bus.rsp_data), 64'(e_rsp_data));
        chk("err", 64'(bus.err), 64'(e_err));
        if (bus.rsp_vld != '0) begin
            n_rsp_total++;
            for (int i = 0; i < NREQ; i++) if (bus.rsp_vld[i]) n_rsp_req[i]++;
            chk("sb_pending", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                item = exp_q.pop_front();
                chk("sb_rsp", 64'({bus.rsp_vld, bus.rsp_data}), 64'(item));
            end
        end
        // Datapath stand-in: returns dp_fn(operand) exactly LAT cycles after dp_vld.
        dl_q.push_back('{bus.dp_vld, bus.dp_num});
        d = dl_q.pop_front();
        bus.dp_res_vld = d.vld;
        bus.dp_res     = d.vld ? dp_fn(d.num) : $urandom;
    endtask

    task automatic do_reset();
        res = 1'b0; bus.req_vld = '0; bus.hold = 1'b0;
        step();
        res = 1'b1;
    endtask

    task automatic idle(input int n);
        bus.req_vld = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- test sequence ----------------
    vec_t tbl [12];
    int   base, base_req [NREQ], hold_cnt;
    bit   done, prev_busy;

    initial begin
        tbl[0]  = '{4'b0100, 4'b0100};
        tbl[1]  = '{4'b1010, 4'b1000};
        tbl[2]  = '{4'b1010, 4'b0010};
        tbl[3]  = '{4'b0000, 4'b0000};
        tbl[4]  = '{4'b1010, 4'b1000};
        tbl[5]  = '{4'b1010, 4'b0010};
        tbl[6]  = '{4'b0101, 4'b0100};
        tbl[7]  = '{4'b0011, 4'b0001};
        tbl[8]  = '{4'b1111, 4'b0010};
        tbl[9]  = '{4'b1001, 4'b1000};
        tbl[10] = '{4'b1001, 4'b0001};
        tbl[11] = '{4'b0001, 4'b0001};

        n_checks = 0; n_errors = 0; n_rsp_total = 0; cyc = 0;
        for (int i = 0; i < NREQ; i++) n_rsp_req[i] = 0;
        res = 1'b0; bus.hold = 1'b0; bus.req_vld = '0; bus.req_data = '0;
        bus.dp_res = '0; bus.dp_res_vld = 1'b0;
        for (int i = 0; i < LAT; i++) dl_q.push_back('{1'b0, 32'h0});
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step();
        chk("reset_dp_vld", 64'(bus.dp_vld), 64'(0));
        chk("reset_err", 64'(bus.err), 64'(0));
        res = 1'b1;

        // Single requester 2 held for 4 cycles: back-to-back grants.
        bus.req_data[95:64] = 32'h3F80_0000;
        bus.req_vld = 4'b0100;
        base = n_rsp_req[2];
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_rdy", 64'(last_rdy), 64'(4'b0100));
        end
        idle(LAT + 4);
        chk("t1_rsp_count", 64'(n_rsp_req[2] - base), 64'(4));

        // All requesters valid: grant order 0,1,2,3,0,1.
        do_reset();
        for (int i = 0; i < NREQ; i++) base_req[i] = n_rsp_req[i];
        bus.req_vld = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            rand_data();
            step();
            chk("t2_gnt", 64'(last_rdy), 64'(NREQ'(1) << (k % NREQ)));
        end
        idle(LAT + 4);
        chk("t2_rsp0", 64'(n_rsp_req[0] - base_req[0]), 64'(2));
        chk("t2_rsp1", 64'(n_rsp_req[1] - base_req[1]), 64'(2));
        chk("t2_rsp3", 64'(n_rsp_req[3] - base_req[3]), 64'(1));
        chk("t2_err", 64'(bus.err), 64'(0));

        // Grant vector table, including the pointer-at-2 case with requesters 1 and 3.
        do_reset();
        for (int v = 0; v < 12; v++) begin
            bus.req_vld = tbl[v].vld;
            rand_data();
            step();
            chk("tbl_rdy", 64'(last_rdy), 64'(tbl[v].rdy));
        end
        idle(LAT + 4);

        // Hold with 3 operations in flight.
        bus.req_vld = 4'b0001;
        for (int i = 0; i < 3; i++) begin rand_data(); step(); end
        base = n_rsp_total;
        bus.hold = 1'b1; bus.req_vld = 4'b1111;
        step();
        chk("t4_rdy_hold", 64'(last_rdy), 64'(0));
        done = 0; prev_busy = last_busy;
        for (int k = 0; k < 20 && !done; k++) begin
            prev_busy = last_busy;
            step();
            if (last_hold_ack) done = 1;
        end
        chk("t4_ack_seen", 64'(done), 64'(1));
        chk("t4_idle_before_ack", 64'(prev_busy), 64'(0));
        chk("t4_rsp_count", 64'(n_rsp_total - base), 64'(3));
        bus.hold = 1'b0;
        step();
        chk("t4_ack_at_fall", 64'(last_hold_ack), 64'(1));
        step();
        chk("t4_ack_clear", 64'(last_hold_ack), 64'(0));
        chk("t4_resume", 64'(last_rdy != '0), 64'(1));
        idle(LAT + 4);

        // Spurious datapath result.
        do_reset();
        idle(2);
        base = n_rsp_total;
        bus.dp_res_vld = 1'b1; bus.dp_res = $urandom;
        step();
        chk("t5_err_set", 64'(bus.err), 64'(1));
        chk("t5_no_rsp", 64'(bus.rsp_vld), 64'(0));
        idle(5);
        chk("t5_err_sticky", 64'(bus.err), 64'(1));
        chk("t5_rsp_none", 64'(n_rsp_total - base), 64'(0));
        do_reset();
        chk("t5_err_cleared", 64'(bus.err), 64'(0));

        // Reset with 2 operations in flight.
        idle(2);
        bus.req_vld = 4'b0011;
        for (int i = 0; i < 2; i++) begin rand_data(); step(); end
        idle(1);
        do_reset();
        chk("t6_dp_vld", 64'(bus.dp_vld), 64'(0));
        chk("t6_rsp_vld", 64'(bus.rsp_vld), 64'(0));
        chk("t6_err", 64'(bus.err), 64'(0));
        base = n_rsp_total;
        idle(LAT + 3);
        chk("t6_no_late_rsp", 64'(n_rsp_total - base), 64'(0));
        bus.req_vld = 4'b1111; rand_data();
        step();
        chk("t6_ptr_zero", 64'(last_rdy), 64'(4'b0001));
        idle(LAT + 3);

        // Randomized soak with hold episodes and occasional mid-flight reset.
        do_reset();
        hold_cnt = 0;
        for (int n = 0; n < 800; n++) begin
            bus.req_vld = NREQ'($urandom);
            rand_data();
            if (hold_cnt > 0) hold_cnt--;
            else if ($urandom_range(0, 99) < 4) hold_cnt = $urandom_range(1, 12);
            bus.hold = (hold_cnt > 0);
            res = ($urandom_range(0, 299) != 0);
            step();
        end
        res = 1'b1; bus.hold = 1'b0;
        idle(LAT + 4);
        chk("sb_leftover", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
